// File: rtl/fx_bus_arb.sv
// Two-master arbiter for the fx register bus: one transaction at a time,
// round-robin on contention, waits out the slave read latency, acks the owner.
module fx_bus_arb #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [21:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [21:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic        fx_wr,
  output logic        fx_rd,
  output logic [21:0] fx_waddr,
  output logic [21:0] fx_raddr,
  output logic [7:0]  fx_data,
  input  logic [7:0]  fx_q,
  output logic        gnt
);
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [7:0]  wdata;
  } fx_req_t;

  state_t     state, state_nxt;
  fx_req_t    req_q;
  logic       last_gnt, win, grant;
  logic [3:0] cnt;

  // On a tie the requester that did not own the previous grant wins.
  always_comb begin
    win = m1_req;
    if (m0_req && m1_req) win = ~last_gnt;
  end

  assign grant = (state == IDLE) && (m0_req || m1_req);

  always_comb begin
    state_nxt = state;
    fx_wr     = 1'b0;
    fx_rd     = 1'b0;
    fx_waddr  = '0;
    fx_raddr  = '0;
    fx_data   = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    case (state)
      IDLE: if (grant) state_nxt = STROBE;
      STROBE: begin
        if (req_q.we) begin
          fx_wr     = 1'b1;
          fx_waddr  = req_q.addr;
          fx_data   = req_q.wdata;
          state_nxt = DONE;
        end else begin
          fx_rd     = 1'b1;
          fx_raddr  = req_q.addr;
          state_nxt = WAIT;
        end
      end
      WAIT: if (cnt == 4'd0) state_nxt = DONE;
      DONE: begin
        m0_ack    = ~gnt;
        m1_ack    = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      req_q    <= '0;
      cnt      <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt      <= win;
        last_gnt <= win;
        req_q    <= win ? fx_req_t'{m1_we, m1_addr, m1_wdata}
                        : fx_req_t'{m0_we, m0_addr, m0_wdata};
      end
      case (state)
        STROBE: if (!req_q.we) cnt <= 4'(RD_LAT - 1);
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else if (gnt)    m1_rdata <= fx_q;
          else             m0_rdata <= fx_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fx_bus_arb.sv
// Bench for fx_bus_arb: two instances (RD_LAT 1 and 3), directed vector table,
// corner-case sequences and a randomized run against a transaction-level model.
module tb_fx_bus_arb;
  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        m0_req [2], m1_req [2], m0_we [2], m1_we [2];
  logic [21:0] m0_addr [2], m1_addr [2];
  logic [7:0]  m0_wdata [2], m1_wdata [2];
  logic        m0_ack [2], m1_ack [2];
  logic [7:0]  m0_rdata [2], m1_rdata [2];
  logic        fx_wr [2], fx_rd [2], gnt [2];
  logic [21:0] fx_waddr [2], fx_raddr [2];
  logic [7:0]  fx_data [2], fx_q [2];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk_sys = ~clk_sys;

  // Slave data is a fixed function of the address; dev_id 0x3F is absent.
  function automatic logic [7:0] slv(logic [21:0] a);
    return (a[21:16] == 6'h3F) ? 8'h00 : (a[7:0] ^ {2'b00, a[21:16]});
  endfunction

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gs
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [LAT:0] rd_sh;
    logic [21:0]  a_sh [LAT+1];

    fx_bus_arb #(.RD_LAT(LAT)) u_dut (
      .clk_sys(clk_sys), .rst_n(rst_n),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_ack(m0_ack[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_ack(m1_ack[g]), .m1_rdata(m1_rdata[g]),
      .fx_wr(fx_wr[g]), .fx_rd(fx_rd[g]), .fx_waddr(fx_waddr[g]), .fx_raddr(fx_raddr[g]),
      .fx_data(fx_data[g]), .fx_q(fx_q[g]), .gnt(gnt[g])
    );

    always @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) rd_sh <= '0;
      else        rd_sh <= {rd_sh[LAT-1:0], fx_rd[g]};
    end
    always @(posedge clk_sys) begin
      a_sh[0] <= fx_raddr[g];
      for (int i = 1; i <= LAT; i++) a_sh[i] <= a_sh[i-1];
    end
    // Valid exactly RD_LAT cycles after fx_rd; a poison byte one cycle late.
    assign fx_q[g] = rd_sh[LAT-1] ? slv(a_sh[LAT-1]) : (rd_sh[LAT] ? 8'hEE : 8'h00);
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic set_req(input int g, input int m, input logic r, input logic we,
                         input logic [21:0] a, input logic [7:0] wd);
    if (m == 0) begin
      m0_req[g] = r; m0_we[g] = we; m0_addr[g] = a; m0_wdata[g] = wd;
    end else begin
      m1_req[g] = r; m1_we[g] = we; m1_addr[g] = a; m1_wdata[g] = wd;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int m = 0; m < 2; m++) set_req(g, m, 1'b0, 1'b0, '0, '0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic get_ack(int g, int m);
    return (m == 0) ? m0_ack[g] : m1_ack[g];
  endfunction

  function automatic logic [7:0] get_rd(int g, int m);
    return (m == 0) ? m0_rdata[g] : m1_rdata[g];
  endfunction

  function automatic logic bus_ok(int g, logic str, logic we, logic [21:0] a, logic [7:0] wd);
    if (!str)
      return !fx_wr[g] && !fx_rd[g] && fx_waddr[g] == 0 && fx_raddr[g] == 0 && fx_data[g] == 0;
    if (we)
      return fx_wr[g] && !fx_rd[g] && fx_waddr[g] == a && fx_raddr[g] == 0 && fx_data[g] == wd;
    return fx_rd[g] && !fx_wr[g] && fx_raddr[g] == a && fx_waddr[g] == 0 && fx_data[g] == 0;
  endfunction

  // One transaction from an idle arbiter; reports strobe/ack cycle offsets.
  task automatic do_txn(input int g, input int m, input logic we, input logic [21:0] a,
                        input logic [7:0] wd, output int s_at, output int k_at,
                        output logic [7:0] rd, output logic ok);
    logic [7:0] other;
    logic       str;
    other = get_rd(g, 1 - m);
    rd    = get_rd(g, m);
    ok    = 1'b1;
    s_at  = -1;
    k_at  = -1;
    set_req(g, m, 1'b1, we, a, wd);
    for (int n = 1; n <= 25 && k_at < 0; n++) begin
      step();
      str = fx_wr[g] | fx_rd[g];
      if (str === 1'b1 && s_at < 0) s_at = n;
      if (bus_ok(g, n == s_at, we, a, wd) !== 1'b1) ok = 1'b0;
      if (get_ack(g, 1 - m) !== 1'b0 || get_rd(g, 1 - m) !== other) ok = 1'b0;
      if (!we && n < k_at && get_rd(g, m) !== rd) ok = 1'b0;
      if (get_ack(g, m) === 1'b1) begin
        k_at = n;
        rd   = get_rd(g, m);
        set_req(g, m, 1'b0, 1'b0, '0, '0);
      end
    end
    step();
    if (get_ack(g, m) !== 1'b0 || bus_ok(g, 1'b0, 1'b0, '0, '0) !== 1'b1) ok = 1'b0;
    if (get_rd(g, m) !== rd) ok = 1'b0;
  endtask

  typedef struct {
    int          g;
    int          m;
    logic        we;
    logic [21:0] a;
    logic [7:0]  wd;
    int          s_exp;
    int          k_exp;
    logic [7:0]  rd_exp;
  } vec_t;

  vec_t        tbl [7];
  int          s_at, k_at, nstr, last_s, acks, nxt, nown, ngnt;
  int          own [4];
  int          gsn [4];
  logic        ok, b2b, anyack;
  logic [7:0]  rd, rdv;

  // Random-run model state, per instance g and master m.
  logic        pend [2][2], prev_req [2][2], rq_we [2][2];
  logic [21:0] rq_a [2][2];
  logic [7:0]  rq_wd [2][2], mdl_rd [2][2], exp_rd [2];
  logic        infl [2], last_w [2], gnt_e [2], w, str_exp, exp_ack, just_acked;
  int          owner [2], ack_at [2], free_at [2];

  initial begin
    tbl[0] = '{0, 0, 1'b1, 22'h040081, 8'h5A, 1, 2, 8'h00};
    tbl[1] = '{0, 1, 1'b0, 22'h040000, 8'h00, 1, 3, 8'h04};
    tbl[2] = '{0, 0, 1'b0, 22'h120033, 8'h00, 1, 3, 8'h21};
    tbl[3] = '{1, 0, 1'b0, 22'h0000A7, 8'h00, 1, 5, 8'hA7};
    tbl[4] = '{1, 1, 1'b0, 22'h05000C, 8'h00, 1, 5, 8'h09};
    tbl[5] = '{1, 1, 1'b0, 22'h3F0010, 8'h00, 1, 5, 8'h00};
    tbl[6] = '{1, 1, 1'b1, 22'h3F1234, 8'h99, 1, 2, 8'h00};

    do_reset();
    for (int g = 0; g < 2; g++) begin
      chk("reset_outs", {fx_wr[g], fx_rd[g], fx_waddr[g], fx_raddr[g], fx_data[g]}, 0);
      chk("reset_m", {m0_ack[g], m1_ack[g], gnt[g], m0_rdata[g], m1_rdata[g]}, 0);
    end

    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i].g, tbl[i].m, tbl[i].we, tbl[i].a, tbl[i].wd, s_at, k_at, rd, ok);
      chk($sformatf("vec%0d_strobe_cyc", i), s_at, tbl[i].s_exp);
      chk($sformatf("vec%0d_ack_cyc", i), k_at, tbl[i].k_exp);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd_exp);
      chk($sformatf("vec%0d_bus_other", i), ok, 1);
    end

    // Tie: both read continuously from reset.
    do_reset();
    set_req(0, 0, 1'b1, 1'b0, 22'h010005, 8'h00);
    set_req(0, 1, 1'b1, 1'b0, 22'h020006, 8'h00);
    nstr = 0; last_s = -10; b2b = 1'b0;
    for (int i = 0; i < 4; i++) begin own[i] = -1; gsn[i] = -1; end
    for (int n = 1; n <= 40 && nstr < 4; n++) begin
      step();
      if ((fx_wr[0] | fx_rd[0]) === 1'b1) begin
        if (n == last_s + 1 || fx_wr[0] === 1'b1) b2b = 1'b1;
        last_s    = n;
        own[nstr] = (fx_raddr[0] == 22'h020006) ? 1 : 0;
        gsn[nstr] = int'(gnt[0]);
        nstr++;
      end
    end
    set_req(0, 0, 1'b0, 1'b0, '0, '0);
    set_req(0, 1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_owner%0d", i), own[i], i % 2);
      chk($sformatf("tie_gnt%0d", i), gsn[i], i % 2);
    end
    chk("tie_no_b2b", b2b, 0);
    for (int n = 0; n < 6; n++) step();

    // Reset pulsed during WAIT of an m0 read (RD_LAT=3), after m1 read earlier.
    do_reset();
    do_txn(1, 1, 1'b0, 22'h05000C, 8'h00, s_at, k_at, rd, ok);
    set_req(1, 0, 1'b1, 1'b0, 22'h00005B, 8'h00);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_bus", {fx_wr[1], fx_rd[1], fx_raddr[1], fx_waddr[1]}, 0);
    chk("rst_async_m", {m0_ack[1], m1_ack[1], gnt[1], m0_rdata[1], m1_rdata[1]}, 0);
    set_req(1, 0, 1'b0, 1'b0, '0, '0);
    step();
    rst_n  = 1'b1;
    anyack = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if ((m0_ack[1] | m1_ack[1] | fx_rd[1] | fx_wr[1]) !== 1'b0) anyack = 1'b1;
    end
    chk("rst_no_ack", anyack, 0);
    set_req(1, 0, 1'b1, 1'b0, 22'h000044, 8'h00);
    set_req(1, 1, 1'b1, 1'b0, 22'h000055, 8'h00);
    step();
    chk("rst_tie_owner", fx_rd[1] === 1'b1 && fx_raddr[1] == 22'h000044, 1);
    chk("rst_tie_gnt", gnt[1], 0);
    set_req(1, 0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1, 1'b0, 1'b0, '0, '0);
    for (int n = 0; n < 8; n++) step();

    // m0 drops req in STROBE while m1 becomes pending.
    do_reset();
    set_req(0, 0, 1'b1, 1'b0, 22'h070011, 8'h00);
    step();
    chk("drop_strobe", fx_rd[0] === 1'b1 && fx_raddr[0] == 22'h070011, 1);
    set_req(0, 0, 1'b0, 1'b0, '0, '0);
    set_req(0, 1, 1'b1, 1'b0, 22'h080022, 8'h00);
    acks = 0; nxt = -1; nown = -1; ngnt = -1; rdv = 8'h00;
    for (int n = 2; n <= 14 && nxt < 0; n++) begin
      step();
      if (m0_ack[0] === 1'b1) begin acks++; rdv = m0_rdata[0]; end
      if ((fx_rd[0] | fx_wr[0]) === 1'b1) begin
        nxt  = n;
        nown = (fx_raddr[0] == 22'h080022) ? 1 : 0;
        ngnt = int'(gnt[0]);
      end
    end
    chk("drop_ack_count", acks, 1);
    chk("drop_rdata", rdv, 8'h16);
    chk("drop_next_cyc", nxt, 5);
    chk("drop_next_owner", nown, 1);
    chk("drop_next_gnt", ngnt, 1);
    set_req(0, 1, 1'b0, 1'b0, '0, '0);
    for (int n = 0; n < 6; n++) step();

    // Randomized traffic on both instances against the transaction model.
    do_reset();
    for (int g = 0; g < 2; g++) begin
      infl[g] = 1'b0; last_w[g] = 1'b1; gnt_e[g] = 1'b0; free_at[g] = 0;
      owner[g] = 0; ack_at[g] = 0; exp_rd[g] = 8'h00;
      for (int m = 0; m < 2; m++) begin
        pend[g][m] = 1'b0; prev_req[g][m] = 1'b0; mdl_rd[g][m] = 8'h00;
        rq_we[g][m] = 1'b0; rq_a[g][m] = '0; rq_wd[g][m] = '0;
      end
    end
    for (int c = 0; c < 500; c++) begin
      step();
      for (int g = 0; g < 2; g++) begin
        str_exp = !infl[g] && (c - 1 >= free_at[g]) && (prev_req[g][0] || prev_req[g][1]);
        chk("rnd_strobe", fx_wr[g] | fx_rd[g], str_exp);
        if (str_exp) begin
          w = (prev_req[g][0] && prev_req[g][1]) ? !last_w[g] : prev_req[g][1];
          last_w[g] = w; gnt_e[g] = w; infl[g] = 1'b1; owner[g] = int'(w);
          ack_at[g] = c + (rq_we[g][w] ? 1 : 1 + lat_of(g));
          exp_rd[g] = slv(rq_a[g][w]);
          chk("rnd_bus", bus_ok(g, 1'b1, rq_we[g][w], rq_a[g][w], rq_wd[g][w]), 1);
        end else begin
          chk("rnd_bus_idle", bus_ok(g, 1'b0, 1'b0, '0, '0), 1);
        end
        chk("rnd_gnt", gnt[g], gnt_e[g]);
        for (int m = 0; m < 2; m++) begin
          exp_ack    = infl[g] && c == ack_at[g] && owner[g] == m;
          just_acked = exp_ack;
          chk("rnd_ack", get_ack(g, m), exp_ack);
          if (exp_ack) begin
            if (!rq_we[g][m]) mdl_rd[g][m] = exp_rd[g];
            infl[g] = 1'b0; free_at[g] = c + 1; pend[g][m] = 1'b0;
          end
          chk("rnd_rdata", get_rd(g, m), mdl_rd[g][m]);
          if (!pend[g][m] && !just_acked && $urandom_range(0, 2) == 0) begin
            pend[g][m]  = 1'b1;
            rq_we[g][m] = 1'($urandom_range(0, 1));
            rq_a[g][m]  = {($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom_range(0, 7)),
                           16'($urandom)};
            rq_wd[g][m] = 8'($urandom);
          end
          set_req(g, m, pend[g][m], rq_we[g][m], pend[g][m] ? rq_a[g][m] : '0,
                  pend[g][m] ? rq_wd[g][m] : '0);
          prev_req[g][m] = pend[g][m];
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
